ahb_sram_slave: RTL and testbench

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_sram_slave_pkg.sv | 51 +++++
 rtl/ahb_sram_bank.sv | 52 +++++
 rtl/ahb_sram_slave.sv | 132 +++++++++++++
 tb/tb_ahb_sram_slave.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings and address-phase helpers for the SRAM slave.
`ifndef AHB_SRAM_DEFINES
`define AHB_SRAM_DEFINES
`define WORD_WIDTH    32
`define HTRANS_IDLE   2'b00
`define HTRANS_BUSY   2'b01
`define HTRANS_NONSEQ 2'b10
`define HTRANS_SEQ    2'b11
`define HRESP_OKAY    2'b00
`define HRESP_ERROR   2'b01
`define HSIZE_BYTE    3'b000
`define HSIZE_HALF    3'b001
`define HSIZE_WORD    3'b010
`endif

package ahb_sram_slave_pkg;

    localparam int unsigned WordWidth    = `WORD_WIDTH;
    localparam logic [1:0]  HtransNonseq = `HTRANS_NONSEQ;
    localparam logic [1:0]  HtransSeq    = `HTRANS_SEQ;
    localparam logic [1:0]  HrespOkay    = `HRESP_OKAY;
    localparam logic [1:0]  HrespError   = `HRESP_ERROR;
    localparam logic [2:0]  HsizeByte    = `HSIZE_BYTE;
    localparam logic [2:0]  HsizeHalf    = `HSIZE_HALF;
    localparam logic [2:0]  HsizeWord    = `HSIZE_WORD;

    // Little-endian byte lanes touched by a transfer of the given size.
    function automatic logic [3:0] lane_enables(input logic [2:0] size,
                                                input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            HsizeByte: be = 4'b0001 << addr_lo;
            HsizeHalf: be = 4'b0011 << {addr_lo[1], 1'b0};
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic size_aligned(input logic [2:0] size,
                                          input logic [1:0] addr_lo);
        logic ok;
        case (size)
            HsizeByte: ok = 1'b1;
            HsizeHalf: ok = ~addr_lo[0];
            HsizeWord: ok = (addr_lo == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Word-organised SRAM with byte-write enables, synchronous write and synchronous read.
module ahb_sram_bank #(
    parameter int unsigned Depth     = 1024,
    parameter int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [3:0]           we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [31:0]          wdata_i,
    input  logic                 re_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [31:0]          rdata_o
);

    logic [31:0] mem_q [Depth];
    logic [31:0] rdata_d, rdata_q;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Write-first: a read landing on the word being written sees the new bytes.
    always_comb begin
        rdata_d = '0;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
            if (raddr_i == waddr_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (we_i[b]) begin
                        rdata_d[8*b +: 8] = wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable read/write wait states and two-cycle error response.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned RD_WAIT = 1,
    parameter int unsigned WR_WAIT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WordWidth-1:0] D_HADDR,
    input  logic                 D_HWRITE,
    input  logic [2:0]           D_HSIZE,
    input  logic [2:0]           D_HBURST,
    input  logic [1:0]           D_HTRANS,
    input  logic                 D_HMASTLOCK,
    input  logic [WordWidth-1:0] D_HWDATA,
    output logic [WordWidth-1:0] D_HRDATA,
    output logic                 D_HREADY,
    output logic [1:0]           D_HRESP
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {StIdle, StWait, StDone, StErr1, StErr2} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [3:0]    be_q;
    logic          wr_q;
    logic          ready_q, ready_d;
    logic [1:0]    resp_q, resp_d;

    logic          req_valid, accept, in_range, legal;
    logic [AW-1:0] req_idx;
    logic [3:0]    req_wait;
    logic          xfer_wr;
    logic [AW-1:0] xfer_idx;
    logic          bank_re;
    logic [3:0]    bank_we;

    logic unused_ok;
    assign unused_ok = ^{D_HBURST, D_HMASTLOCK};

    assign req_valid = (D_HTRANS == HtransNonseq) || (D_HTRANS == HtransSeq);
    assign accept    = req_valid && ((state_q == StIdle) || ready_q);
    assign in_range  = (D_HADDR[WordWidth-1:AW+2] == '0);
    assign legal     = in_range && size_aligned(D_HSIZE, D_HADDR[1:0]);
    assign req_idx   = D_HADDR[AW+1:2];
    assign req_wait  = D_HWRITE ? 4'(WR_WAIT) : 4'(RD_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            resp_q  <= HrespOkay;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            resp_q  <= resp_d;
            if (accept) begin
                idx_q <= req_idx;
                be_q  <= lane_enables(D_HSIZE, D_HADDR[1:0]);
                wr_q  <= D_HWRITE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle, StDone, StErr2: begin
                state_d = StIdle;
                if (accept) begin
                    if (!legal) begin
                        state_d = StErr1;
                    end else if (req_wait != 4'd0) begin
                        state_d = StWait;
                        cnt_d   = req_wait;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_d = (state_d == StDone) || (state_d == StErr2);
        resp_d  = ((state_d == StErr1) || (state_d == StErr2)) ? HrespError : HrespOkay;
    end

    // With zero read wait the bank must be addressed straight from the bus.
    assign xfer_wr  = accept ? D_HWRITE : wr_q;
    assign xfer_idx = accept ? req_idx : idx_q;
    assign bank_re  = (state_d == StDone) && !xfer_wr;
    assign bank_we  = ((state_q == StDone) && wr_q) ? be_q : 4'b0000;

    ahb_sram_bank #(
        .Depth    (DEPTH),
        .AddrWidth(AW)
    ) u_bank (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .we_i   (bank_we),
        .waddr_i(idx_q),
        .wdata_i(D_HWDATA),
        .re_i   (bank_re),
        .raddr_i(xfer_idx),
        .rdata_o(D_HRDATA)
    );

    assign D_HREADY = ready_q;
    assign D_HRESP  = resp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: default-timing slave driven from a vector table, plus a slow-timing twin.
module tb_ahb_sram_slave;

    localparam int RD0 = 1;
    localparam int WR0 = 0;
    localparam int RD1 = 3;
    localparam int WR1 = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata0, hrdata1;
    logic        hready0, hready1;
    logic [1:0]  hresp0, hresp1;

    int n_total = 0;
    int n_pass  = 0;

    ahb_sram_slave #(.DEPTH(1024), .RD_WAIT(RD0), .WR_WAIT(WR0)) dut0 (
        .clk(clk), .rst_n(rst_n), .D_HADDR(haddr), .D_HWRITE(hwrite), .D_HSIZE(hsize),
        .D_HBURST(hburst), .D_HTRANS(htrans), .D_HMASTLOCK(hmastlock), .D_HWDATA(hwdata),
        .D_HRDATA(hrdata0), .D_HREADY(hready0), .D_HRESP(hresp0)
    );

    ahb_sram_slave #(.DEPTH(1024), .RD_WAIT(RD1), .WR_WAIT(WR1)) dut1 (
        .clk(clk), .rst_n(rst_n), .D_HADDR(haddr), .D_HWRITE(hwrite), .D_HSIZE(hsize),
        .D_HBURST(hburst), .D_HTRANS(htrans), .D_HMASTLOCK(hmastlock), .D_HWDATA(hwdata),
        .D_HRDATA(hrdata1), .D_HREADY(hready1), .D_HRESP(hresp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err,
                                input logic [31:0] rdata);
        vec_t v;
        v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        htrans = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One transfer on dut0; called 1 time unit after a rising edge.
    task automatic xfer(input string name, input vec_t v, input logic [1:0] trans);
        int         lat;
        logic       pre_ok;
        int         exp_lat;
        logic [1:0] exp_resp;
        exp_resp = v.err ? 2'b01 : 2'b00;
        exp_lat  = v.err ? 2 : (v.wr ? WR0 + 1 : RD0 + 1);
        haddr  = v.addr;
        hwrite = v.wr;
        hsize  = v.size;
        htrans = trans;
        @(posedge clk);
        #1;
        htrans = 2'b00;
        hwdata = v.wdata;
        lat    = -1;
        pre_ok = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (hready0) begin
                lat = c;
                break;
            end
            if (hresp0 !== exp_resp) pre_ok = 1'b0;
        end
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_resp"}, {30'd0, hresp0}, {30'd0, exp_resp});
        chk({name, "_rdata"}, hrdata0, (v.wr || v.err) ? 32'h0 : v.rdata);
        chk({name, "_preresp"}, {31'd0, pre_ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Read on dut1 while the bus address wanders during the wait states.
    task automatic rd1_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        int          lat;
        logic [31:0] rd;
        logic [1:0]  rs;
        haddr  = addr;
        hwrite = 1'b0;
        hsize  = 3'd2;
        htrans = 2'b10;
        @(posedge clk);
        #1;
        haddr = addr + 32'h4;
        lat   = -1;
        rd    = '0;
        rs    = 2'b11;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (hready1) begin
                lat    = c;
                rd     = hrdata1;
                rs     = hresp1;
                htrans = 2'b00;
                break;
            end
        end
        htrans = 2'b00;
        chk({name, "_lat"}, 32'(lat), 32'(RD1 + 1));
        chk({name, "_rdata"}, rd, exp);
        chk({name, "_resp"}, {30'd0, rs}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0;
        htrans = 2'b00; hmastlock = 1'b0; hwdata = '0;

        vecs[0]  = mk(1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF);
        vecs[2]  = mk(1'b1, 3'd2, 32'h10,   32'h11223344, 1'b0, 32'h0);
        vecs[3]  = mk(1'b1, 3'd0, 32'h13,   32'hAA000000, 1'b0, 32'h0);
        vecs[4]  = mk(1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'hAA223344);
        vecs[5]  = mk(1'b1, 3'd1, 32'h12,   32'h55660000, 1'b0, 32'h0);
        vecs[6]  = mk(1'b1, 3'd0, 32'h10,   32'h000000EE, 1'b0, 32'h0);
        vecs[7]  = mk(1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'h556633EE);
        vecs[8]  = mk(1'b0, 3'd2, 32'h1000, 32'h0,        1'b1, 32'h0);
        vecs[9]  = mk(1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'h556633EE);
        vecs[10] = mk(1'b1, 3'd2, 32'h12,   32'hFFFFFFFF, 1'b1, 32'h0);
        vecs[11] = mk(1'b1, 3'd1, 32'h11,   32'hFFFFFFFF, 1'b1, 32'h0);
        vecs[12] = mk(1'b1, 3'd3, 32'h10,   32'hFFFFFFFF, 1'b1, 32'h0);
        vecs[13] = mk(1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'h556633EE);
        vecs[14] = mk(1'b1, 3'd2, 32'hFFC,  32'hCAFEF00D, 1'b0, 32'h0);
        vecs[15] = mk(1'b0, 3'd2, 32'hFFC,  32'h0,        1'b0, 32'hCAFEF00D);
        vecs[16] = mk(1'b1, 3'd1, 32'hFFE,  32'h12340000, 1'b0, 32'h0);
        vecs[17] = mk(1'b0, 3'd0, 32'hFFD,  32'h0,        1'b0, 32'h1234F00D);

        // Outputs while held in reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hready0", {31'd0, hready0}, 32'd0);
        chk("rst_hresp0", {30'd0, hresp0}, 32'd0);
        chk("rst_hrdata0", hrdata0, 32'd0);
        chk("rst_hready1", {31'd0, hready1}, 32'd0);
        chk("rst_hresp1", {30'd0, hresp1}, 32'd0);
        chk("rst_hrdata1", hrdata1, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            xfer($sformatf("v%0d", i), vecs[i], (i % 2 == 0) ? 2'b10 : 2'b11);
        end

        // Back-to-back: read issued in the write completion cycle
        haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
        @(posedge clk);
        #1;
        hwdata = 32'h5; hwrite = 1'b0;
        @(negedge clk);
        chk("b2b_wr_ready", {31'd0, hready0}, 32'd1);
        @(posedge clk);
        #1 htrans = 2'b00;
        @(negedge clk);
        chk("b2b_rd_wait", {31'd0, hready0}, 32'd0);
        @(negedge clk);
        chk("b2b_rd_ready", {31'd0, hready0}, 32'd1);
        chk("b2b_rd_data", hrdata0, 32'h5);
        @(posedge clk);
        #1;

        // Slow twin: long read wait, address wandering during WAIT
        do_reset();
        xfer("w40", mk(1'b1, 3'd2, 32'h40, 32'h13579BDF, 1'b0, 32'h0), 2'b10);
        repeat (4) @(posedge clk);
        #1;
        rd1_check("rdwait3", 32'h40, 32'h13579BDF);

        // Reset in the middle of a write: nothing committed
        repeat (2) @(posedge clk);
        #1;
        haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
        @(posedge clk);
        #1;
        htrans = 2'b00; hwdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("midwr_wait1", {31'd0, hready1}, 32'd0);
        chk("midwr_done0", {31'd0, hready0}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midwr_rst_hready0", {31'd0, hready0}, 32'd0);
        chk("midwr_rst_hready1", {31'd0, hready1}, 32'd0);
        chk("midwr_rst_hresp1", {30'd0, hresp1}, 32'd0);
        chk("midwr_rst_hrdata1", hrdata1, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd1_check("rst_nocommit1", 32'h40, 32'h13579BDF);
        repeat (2) @(posedge clk);
        #1;
        xfer("rst_nocommit0", mk(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 32'h13579BDF), 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
